// File: rtl/alu_pkg.sv
// Shared definitions for the registered execute-stage ALU.
// Command encodings, FSM states and flag bit positions.
package alu_pkg;

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_MUL = 4'b1010;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_e;

    localparam int FLAG_V = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 3;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per step.
// prod_o already includes the current step's partial product.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] prod_o
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_next;

    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign prod_o   = acc_next;
    assign last_o   = (cnt_q == CNT_W'(WIDTH - 1));

    // Load operands on start, otherwise advance one bit when stepped
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (step_i) begin
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            acc_d    = acc_next;
            cnt_d    = cnt_q + 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_seq_exec.sv
// Registered execute-stage ALU with valid/ready on both sides.
// Single-cycle ops load the output register directly; MUL iterates.
module alu_seq_exec
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int TAG_W  = 4,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       exe_cmd,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val2,
    input  logic             c_in,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             n_out,
    output logic             z_out,
    output logic             c_out,
    output logic             v_out,
    output logic             out_err,
    output logic [TAG_W-1:0] tag_out
);

    state_e state_q, state_d;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [3:0]       flags_q, flags_d;
    logic             err_q, err_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [TAG_W-1:0] mtag_q, mtag_d;
    logic             mc_q, mc_d;

    logic             out_free;
    logic             accept;
    logic             is_mul;
    logic             single_load;
    logic             mul_load;
    logic             mul_step;
    logic             mul_last;
    logic [WIDTH-1:0] mul_prod;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH:0]   sum;
    logic             alu_c;
    logic             alu_v;
    logic             alu_err;

    assign out_free    = !valid_q || out_ready;
    assign accept      = in_valid && in_ready;
    assign is_mul      = (MUL_EN != 0) && (exe_cmd == CMD_MUL);
    assign single_load = accept && !is_mul;
    assign mul_load    = (state_q == ST_MUL_BUSY) && mul_last && out_free;
    assign mul_step    = (state_q == ST_MUL_BUSY) && (!mul_last || out_free);

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start_i (accept && is_mul),
        .step_i  (mul_step),
        .a_i     (val1),
        .b_i     (val2),
        .last_o  (mul_last),
        .prod_o  (mul_prod)
    );

    // Single-cycle op result and carry/overflow; unknown codes flag an error
    always_comb begin
        alu_res = '0;
        sum     = '0;
        alu_c   = c_in;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        unique case (exe_cmd)
            CMD_MOV: alu_res = val2;
            CMD_MVN: alu_res = ~val2;
            CMD_AND: alu_res = val1 & val2;
            CMD_ORR: alu_res = val1 | val2;
            CMD_EOR: alu_res = val1 ^ val2;
            CMD_ADD, CMD_ADC: begin
                sum = {1'b0, val1} + {1'b0, val2}
                    + {{WIDTH{1'b0}}, (exe_cmd == CMD_ADC) && c_in};
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (val1[WIDTH-1] == val2[WIDTH-1])
                       && (alu_res[WIDTH-1] != val1[WIDTH-1]);
            end
            CMD_SUB, CMD_SBC: begin
                sum = {1'b0, val1} - {1'b0, val2}
                    - {{WIDTH{1'b0}}, (exe_cmd == CMD_SBC) && !c_in};
                alu_res = sum[WIDTH-1:0];
                alu_c   = !sum[WIDTH];
                alu_v   = (val1[WIDTH-1] != val2[WIDTH-1])
                       && (alu_res[WIDTH-1] != val1[WIDTH-1]);
            end
            default: begin
                alu_res = '0;
                alu_err = 1'b1;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: MUL runs until its final step writes the output
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (accept && is_mul) state_d = ST_MUL_BUSY;
            ST_MUL_BUSY: if (mul_load) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // FSM output: accept only when idle and the output slot can be reused
    always_comb begin
        in_ready = 1'b0;
        if (!rst && state_q == ST_IDLE && out_free) begin
            in_ready = 1'b1;
        end
    end

    // Output register and MUL side-band next state
    always_comb begin
        valid_d = valid_q;
        res_d   = res_q;
        flags_d = flags_q;
        err_d   = err_q;
        tag_d   = tag_q;
        mtag_d  = mtag_q;
        mc_d    = mc_q;
        if (accept && is_mul) begin
            mtag_d = tag_in;
            mc_d   = c_in;
        end
        if (single_load) begin
            valid_d         = 1'b1;
            res_d           = alu_res;
            err_d           = alu_err;
            tag_d           = tag_in;
            flags_d[FLAG_N] = alu_res[WIDTH-1];
            flags_d[FLAG_Z] = (alu_res == '0);
            flags_d[FLAG_C] = alu_c;
            flags_d[FLAG_V] = alu_v;
        end else if (mul_load) begin
            valid_d         = 1'b1;
            res_d           = mul_prod;
            err_d           = 1'b0;
            tag_d           = mtag_q;
            flags_d[FLAG_N] = mul_prod[WIDTH-1];
            flags_d[FLAG_Z] = (mul_prod == '0);
            flags_d[FLAG_C] = mc_q;
            flags_d[FLAG_V] = 1'b0;
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Output and side-band registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            res_q   <= '0;
            flags_q <= '0;
            err_q   <= 1'b0;
            tag_q   <= '0;
            mtag_q  <= '0;
            mc_q    <= 1'b0;
        end else begin
            valid_q <= valid_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            err_q   <= err_d;
            tag_q   <= tag_d;
            mtag_q  <= mtag_d;
            mc_q    <= mc_d;
        end
    end

    assign out_valid = valid_q;
    assign result    = res_q;
    assign n_out     = flags_q[FLAG_N];
    assign z_out     = flags_q[FLAG_Z];
    assign c_out     = flags_q[FLAG_C];
    assign v_out     = flags_q[FLAG_V];
    assign out_err   = err_q;
    assign tag_out   = tag_q;

endmodule

// File: tb/tb_alu_seq_exec.sv
// Directed bench for alu_seq_exec (WIDTH=32).
// A second instance with MUL_EN=0 covers MUL-as-invalid.
module tb_alu_seq_exec;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_valid0;
    logic [3:0]  exe_cmd;
    logic [31:0] val1;
    logic [31:0] val2;
    logic        c_in;
    logic [3:0]  tag_in;
    logic        out_ready;

    logic        in_ready, out_valid, n_out, z_out, c_out, v_out, out_err;
    logic [31:0] result;
    logic [3:0]  tag_out;

    logic        in_ready0, out_valid0, n0, z0, c0, v0, err0;
    logic [31:0] result0;
    logic [3:0]  tag0;

    int checks = 0;
    int errors = 0;

    alu_seq_exec #(.WIDTH(32), .TAG_W(4), .MUL_EN(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .exe_cmd   (exe_cmd),
        .val1      (val1),
        .val2      (val2),
        .c_in      (c_in),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .n_out     (n_out),
        .z_out     (z_out),
        .c_out     (c_out),
        .v_out     (v_out),
        .out_err   (out_err),
        .tag_out   (tag_out)
    );

    alu_seq_exec #(.WIDTH(32), .TAG_W(4), .MUL_EN(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid0),
        .in_ready  (in_ready0),
        .exe_cmd   (exe_cmd),
        .val1      (val1),
        .val2      (val2),
        .c_in      (c_in),
        .tag_in    (tag_in),
        .out_valid (out_valid0),
        .out_ready (out_ready),
        .result    (result0),
        .n_out     (n0),
        .z_out     (z0),
        .c_out     (c0),
        .v_out     (v0),
        .out_err   (err0),
        .tag_out   (tag0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input string name, input logic [3:0] cmd,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic c, input logic [3:0] t);
        exe_cmd  = cmd;
        val1     = a;
        val2     = b;
        c_in     = c;
        tag_in   = t;
        in_valid = 1'b1;
        chk({name, "_rdy"}, 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    function automatic logic [3:0] fl();
        return {n_out, z_out, c_out, v_out};
    endfunction

    int  cyc;
    bit  early;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_valid0 = 1'b0;
        exe_cmd   = 4'd0;
        val1      = '0;
        val2      = '0;
        c_in      = 1'b0;
        tag_in    = 4'd0;
        out_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_rdy", 64'(in_ready), 64'd0);
        chk("rst_res", 64'(result), 64'd0);
        chk("rst_misc", 64'({fl(), out_err, tag_out}), 64'd0);
        rst = 1'b0;
        #1;
        chk("idle_rdy", 64'(in_ready), 64'd1);

        op("add", 4'b0010, 32'h7FFF_FFFF, 32'h1, 1'b0, 4'd3);
        chk("add_valid", 64'(out_valid), 64'd1);
        chk("add_res", 64'(result), 64'h8000_0000);
        chk("add_flags", 64'(fl()), 64'(4'b1001));
        chk("add_tag", 64'(tag_out), 64'd3);
        chk("add_err", 64'(out_err), 64'd0);

        op("sub", 4'b0100, 32'd5, 32'd5, 1'b0, 4'd4);
        chk("sub_res", 64'(result), 64'd0);
        chk("sub_flags", 64'(fl()), 64'(4'b0110));

        op("sbc", 4'b0101, 32'd5, 32'd3, 1'b0, 4'd5);
        chk("sbc_res", 64'(result), 64'd1);
        chk("sbc_flags", 64'(fl()), 64'(4'b0010));

        op("sub2", 4'b0100, 32'd3, 32'd5, 1'b1, 4'd6);
        chk("sub2_res", 64'(result), 64'hFFFF_FFFE);
        chk("sub2_flags", 64'(fl()), 64'(4'b1000));

        op("adc", 4'b0011, 32'hFFFF_FFFF, 32'h0, 1'b1, 4'd7);
        chk("adc_res", 64'(result), 64'd0);
        chk("adc_flags", 64'(fl()), 64'(4'b0110));

        op("mvn", 4'b1001, 32'd0, 32'h0000_00FF, 1'b1, 4'd8);
        chk("mvn_res", 64'(result), 64'hFFFF_FF00);
        chk("mvn_flags", 64'(fl()), 64'(4'b1010));

        op("mul", 4'b1010, 32'h0000_FFFF, 32'h0001_0001, 1'b1, 4'd9);
        cyc   = 1;
        early = 1'b0;
        chk("mul_busy", 64'(in_ready), 64'd0);
        while (!in_ready && cyc < 100) begin
            if (out_valid && cyc > 1) early = 1'b1;
            tick();
            if (!in_ready) cyc++;
        end
        chk("mul_lat", 64'(cyc), 64'd32);
        chk("mul_early", 64'(early), 64'd0);
        chk("mul_valid", 64'(out_valid), 64'd1);
        chk("mul_res", 64'(result), 64'hFFFF_FFFF);
        chk("mul_flags", 64'(fl()), 64'(4'b1010));
        chk("mul_tag", 64'(tag_out), 64'd9);
        chk("mul_err", 64'(out_err), 64'd0);

        tick();
        chk("drain", 64'(out_valid), 64'd0);

        op("inv", 4'b0000, 32'd7, 32'd9, 1'b1, 4'd2);
        chk("inv_err", 64'(out_err), 64'd1);
        chk("inv_res", 64'(result), 64'd0);
        chk("inv_flags", 64'(fl()), 64'(4'b0110));
        chk("inv_tag", 64'(tag_out), 64'd2);

        exe_cmd   = 4'b1010;
        val1      = 32'd3;
        val2      = 32'd4;
        c_in      = 1'b0;
        tag_in    = 4'd1;
        in_valid0 = 1'b1;
        chk("nomul_rdy", 64'(in_ready0), 64'd1);
        tick();
        in_valid0 = 1'b0;
        chk("nomul_err", 64'(err0), 64'd1);
        chk("nomul_res", 64'(result0), 64'd0);
        chk("nomul_flags", 64'({n0, z0, c0, v0}), 64'(4'b0100));
        chk("nomul_valid", 64'(out_valid0), 64'd1);
        tick();

        out_ready = 1'b0;
        op("bp_add", 4'b0010, 32'd1, 32'd2, 1'b0, 4'd10);
        chk("bp_res1", 64'(result), 64'd3);
        exe_cmd  = 4'b0111;
        val1     = 32'hF0;
        val2     = 32'h0F;
        tag_in   = 4'd11;
        in_valid = 1'b1;
        chk("bp_rdy", 64'(in_ready), 64'd0);
        tick();
        chk("bp_hold_res", 64'(result), 64'd3);
        chk("bp_hold_tag", 64'(tag_out), 64'd10);
        chk("bp_hold_vld", 64'(out_valid), 64'd1);
        tick();
        chk("bp_hold2", 64'(result), 64'd3);
        out_ready = 1'b1;
        #1;
        chk("bp_rdy2", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_res2", 64'(result), 64'hFF);
        chk("bp_tag2", 64'(tag_out), 64'd11);
        chk("bp_vld2", 64'(out_valid), 64'd1);
        tick();
        chk("bp_drain", 64'(out_valid), 64'd0);

        op("rmul", 4'b1010, 32'h1234, 32'h5678, 1'b1, 4'd12);
        for (int i = 0; i < 9; i++) tick();
        chk("rmul_busy", 64'(in_ready), 64'd0);
        rst = 1'b1;
        #1;
        chk("rmul_vld", 64'(out_valid), 64'd0);
        chk("rmul_res", 64'(result), 64'd0);
        chk("rmul_misc", 64'({fl(), out_err, tag_out}), 64'd0);
        chk("rmul_rdy", 64'(in_ready), 64'd0);
        tick();
        tick();
        rst   = 1'b0;
        early = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid) early = 1'b1;
        end
        chk("rmul_stale", 64'(early), 64'd0);

        op("add4", 4'b0010, 32'd2, 32'd2, 1'b0, 4'd13);
        chk("add4_res", 64'(result), 64'd4);
        chk("add4_vld", 64'(out_valid), 64'd1);
        chk("add4_tag", 64'(tag_out), 64'd13);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
